// File: rtl/dp_ram_fifo_ctrl_pkg.sv
// Shared sizing constants for the 16x8 RAM FIFO and its controller.
// The enum classifies the accepted request in a given cycle.
package dp_ram_fifo_ctrl_pkg;
    localparam int unsigned FIFO_AW    = 4;
    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_AW;
    localparam int unsigned FIFO_CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } op_e;
endpackage

// File: rtl/dp_ram_fifo_ctrl_if.sv
// Request, RAM-control and status bundle between the FIFO users and the controller.
// The master side is the producer/consumer; the slave side is dp_ram_fifo_ctrl.
interface dp_ram_fifo_ctrl_if
    import dp_ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned AW = FIFO_AW
);
    logic          push;
    logic          pop;
    logic          flush;
    logic          err_clr;
    logic          ram_wr_enb;
    logic          ram_rd_enb;
    logic [AW-1:0] ram_wr_addr;
    logic [AW-1:0] ram_rd_addr;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, pop, flush, err_clr,
        input  ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr, rd_valid,
        input  full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop, flush, err_clr,
        output ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr, rd_valid,
        output full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller that drives a dual-port RAM's enables and addresses.
// Flags come from registered pointers only; write/read enables are same-cycle.
module dp_ram_fifo_ctrl
    import dp_ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_AW,
    parameter int unsigned AF_LEVEL   = 14,
    parameter int unsigned AE_LEVEL   = 2
)(
    input logic                clk,
    input logic                rst,
    dp_ram_fifo_ctrl_if.slave  bus
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          full, empty, push_ok, pop_ok;
    op_e           op;

    always_comb begin
        full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        push_ok = bus.push & ~full & ~bus.flush;
        pop_ok  = bus.pop & ~empty & ~bus.flush;
        op      = op_e'({pop_ok, push_ok});
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = pop_ok;
        overflow_d  = (overflow_q & ~bus.err_clr) | (bus.push & full & ~bus.flush);
        underflow_d = (underflow_q & ~bus.err_clr) | (bus.pop & empty & ~bus.flush);
        // push_ok/pop_ok are already masked by flush, so flush only needs to zero state
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_q + PW'(1);
                end
                OP_POP: begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d  = count_q - PW'(1);
                end
                OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.ram_wr_enb   = push_ok;
    assign bus.ram_rd_enb   = pop_ok;
    assign bus.ram_wr_addr  = wr_ptr_q[PW-2:0];
    assign bus.ram_rd_addr  = rd_ptr_q[PW-2:0];
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= PW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= PW'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
